systolic_skew_feeder: RTL
=========================

# systolic_skew_feeder

Upstream feeder for one edge of the systolic PE array. It accepts one ROWS-wide input vector per handshake and drives each array row's `in_left` input. Row i is delayed by i extra cycles, which gives the diagonal wavefront the PEs expect. It also sequences the array control strobes (`clear_acc`, `enable`, `acc_enable`) for one tile: start, accumulator clear, stream, drain and done.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of one operand; two's complement.
- `ROWS`, 4, number of array rows (lanes); minimum 1.
- `CNT_WIDTH`, 16, width of the beat counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `s_valid`  in  1  input vector valid.
- `s_ready`  out  1  feeder can accept a vector.
- `s_data`  in  ROWS*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_last`  in  1  marks the final vector of the tile; qualified by the handshake.
- `row_data`  out  ROWS*DATA_WIDTH  skewed operands to the array `in_left`; same lane packing as `s_data`.
- `row_valid`  out  ROWS  per-lane valid, travelling with `row_data`.
- `pe_enable`  out  1  array `enable`.
- `acc_enable`  out  1  array `acc_enable`.
- `clear_acc`  out  1  array `clear_acc`; one-cycle pulse.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at tile end.
- `beat_count`  out  CNT_WIDTH  vectors accepted in the current or last tile.

## Operation
- States and transitions:
  - IDLE → CLEAR when `start`=1.
  - CLEAR → STREAM unconditionally (1 cycle).
  - STREAM → FLUSH on a handshake with `s_last`=1.
  - FLUSH → DONE after exactly ROWS cycles.
  - DONE → IDLE unconditionally (1 cycle).
- All outputs are Moore, decoded from the state and registers:
  - `s_ready` = (state==STREAM).
  - `clear_acc` = (state==CLEAR).
  - `pe_enable` = (state ∈ {STREAM, FLUSH}).
  - `acc_enable` = OR of `row_valid`.
  - `done` = (state==DONE).
  - `busy` = (state≠IDLE).
- Handshake: a beat transfers when `s_valid` & `s_ready` are both 1 at a rising edge. `s_data` and `s_last` are ignored otherwise.
- Lane pipelines:
  - Lane i is a shift register of depth i+1 that advances every cycle; the array applies no backpressure.
  - On a handshake, stage 0 of every lane loads its slice of `s_data` with valid=1.
  - On any other cycle, stage 0 loads data=0 with valid=0 (a bubble).
  - Output data is always 0 when the matching valid bit is 0.
- `beat_count`:
  - Cleared to 0 on entry to CLEAR.
  - Increments on each handshake and saturates at 2^CNT_WIDTH−1.
  - Holds its value through FLUSH, DONE and IDLE.
- A `start` asserted in any state other than IDLE is ignored. It is not queued.
- A tile with `s_last` on its first beat is legal: it delivers 1 beat, then FLUSH.
- Reset, at any time including mid-tile: state goes to IDLE immediately and all lane stages are cleared. No `done` pulse is generated.

## Timing
- Reset values: `s_ready`, `clear_acc`, `pe_enable`, `acc_enable`, `busy` and `done` are all 0; `row_data` and `row_valid` are 0; `beat_count` is 0.
- `start` sampled at the edge closing cycle t:
  - cycle t+1: CLEAR, with `clear_acc`=1.
  - cycle t+2: STREAM, with `s_ready`=1.
- A beat accepted at the edge closing cycle c appears on lane i during cycle c+1+i.
- Last beat accepted at cycle L:
  - FLUSH occupies cycles L+1 … L+ROWS.
  - Lane ROWS−1 emits the last operand during cycle L+ROWS.
  - `done`=1 during cycle L+ROWS+1.
  - IDLE from cycle L+ROWS+2.
- Back-to-back tiles: `start` in the first IDLE cycle gives a minimum tile-to-tile gap of 3 cycles (DONE, IDLE, CLEAR).
- `s_ready` drops in the cycle immediately after the `s_last` handshake. No further beat is accepted in that tile.

## Structure
- Shared package `systolic_pkg` holds:
  - the `DATA_WIDTH` / `ROWS` defaults;
  - the feeder state enum (IDLE, CLEAR, STREAM, FLUSH, DONE);
  - the lane-slice helper constant.
- Sub-module `skew_delay_line`:
  - parameterised by `DEPTH` and `DATA_WIDTH`, carrying data and a valid bit;
  - instantiated ROWS times with `DEPTH` = i+1.
- The top level contains the FSM, the FLUSH down-counter (log2(ROWS)+1 bits) and the beat counter.

## Test plan
- Reset mid-STREAM with ROWS=4: assert `rst` with 2 beats in flight → all outputs 0 in the same cycle; `done` never pulses; a later `start` runs a clean tile.
- Single tile, 3 beats, no bubbles, lanes = {1,2,3,4}·k for k=1..3:
  - `clear_acc` pulses 1 cycle after `start`;
  - lane 3 shows 4, 8, 12 in cycles c+4 … c+6;
  - `done` at L+5;
  - `beat_count`=3.
- Bubbles: `s_valid` pattern 1,0,1 with `s_last` on the 3rd beat → lane 0 shows valid 1,0,1; bubble data is 0; `acc_enable` is 0 only when all lanes are invalid; `beat_count`=2.
- Signed data: lanes carry −5 (16'hFFFB) and −3 → values appear bit-exact on their skewed cycles; no sign corruption.
- `start` while busy and a `start` during DONE → both ignored; exactly one `done` per tile; a one-beat tile (`s_last` on first beat) gives `done` at L+ROWS+1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: default sizes, the
// feeder FSM state type and the lane-slice helper used when packing lanes.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ROWS_DEF       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // Least-significant bit of a lane inside a packed ROWS*width vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying one operand lane plus its valid bit.
// Stage 0 captures the input; a non-valid input is stored as a zero bubble
// so the output data is always zero whenever the output valid is zero.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;

    // Advance every stage each cycle; stage 0 loads the operand or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_r[s] <= {DATA_WIDTH{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (in_valid) begin
                data_r[0]  <= in_data;
                valid_r[0] <= 1'b1;
            end else begin
                data_r[0]  <= {DATA_WIDTH{1'b0}};
                valid_r[0] <= 1'b0;
            end
            for (int s = 1; s < DEPTH; s++) begin
                data_r[s]  <= data_r[s-1];
                valid_r[s] <= valid_r[s-1];
            end
        end
    end

    assign out_data  = data_r[DEPTH-1];
    assign out_valid = valid_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewing feeder for one edge of the systolic PE array. Accepts one
// ROWS-wide vector per handshake, delays lane i by i extra cycles and
// sequences the per-tile array strobes (clear, stream, drain, done).
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] s_data,
    input  logic                       s_last,
    output logic [ROWS*DATA_WIDTH-1:0] row_data,
    output logic [ROWS-1:0]            row_valid,
    output logic                       pe_enable,
    output logic                       acc_enable,
    output logic                       clear_acc,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       beat_count
);

    localparam int FCW = $clog2(ROWS) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    feeder_state_t  state_r;
    feeder_state_t  state_next;
    logic [FCW-1:0] flush_cnt_r;
    logic           handshake_s;
    logic           last_beat_s;
    logic           tile_start_s;

    // s_ready is a registered decode of STREAM, so it qualifies the transfer.
    assign handshake_s  = s_valid & s_ready;
    assign last_beat_s  = handshake_s & s_last;
    assign tile_start_s = (state_r == ST_IDLE) & start;

    // Next-state logic for the tile sequencer.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (last_beat_s) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == {FCW{1'b0}}) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus Moore strobes decoded from the next state so the
    // outputs come straight from flops and line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            s_ready   <= 1'b0;
            clear_acc <= 1'b0;
            pe_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_next;
            s_ready   <= (state_next == ST_STREAM);
            clear_acc <= (state_next == ST_CLEAR);
            pe_enable <= (state_next == ST_STREAM) || (state_next == ST_FLUSH);
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
        end
    end

    // Drain counter: FLUSH lasts exactly ROWS cycles so the deepest lane
    // has emitted the final operand before DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= {FCW{1'b0}};
        end else if ((state_r == ST_STREAM) && last_beat_s) begin
            flush_cnt_r <= FCW'(ROWS - 1);
        end else if ((state_r == ST_FLUSH) && (flush_cnt_r != {FCW{1'b0}})) begin
            flush_cnt_r <= flush_cnt_r - FCW'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Saturating count of accepted vectors, cleared when a tile starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= {CNT_WIDTH{1'b0}};
        end else if (tile_start_s) begin
            beat_count <= {CNT_WIDTH{1'b0}};
        end else if (handshake_s && (beat_count != CNT_MAX)) begin
            beat_count <= beat_count + CNT_WIDTH'(1);
        end else begin
            beat_count <= beat_count;
        end
    end

    // One delay line per lane; lane i is i+1 stages deep.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, DATA_WIDTH);
        skew_delay_line #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .in_data   (s_data[LSB +: DATA_WIDTH]),
            .in_valid  (handshake_s),
            .out_data  (row_data[LSB +: DATA_WIDTH]),
            .out_valid (row_valid[i])
        );
    end

    assign acc_enable = |row_valid;

endmodule
